// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SAVE     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_RET      = 2'd3
  } trap_state_e;

  localparam int CAUSE_ILLEGAL  = 2;
  localparam int CAUSE_BREAK    = 3;
  localparam int CAUSE_ECALL_M  = 11;
  localparam int IRQ_CAUSE_BASE = 16;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled interrupt lines.
module irq_prio_enc #(
  parameter int NUM_IRQ = 4,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Scan downward so the lowest asserted index is the last one written.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap sequencer: owns mepc/mcause/mtval/mstatus.MIE/MPIE.
// Define TRAP_VECTORED_EN to enable vectored interrupt dispatch (mtvec[1:0]==01).
module trap_unit
  import trap_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_IRQ     = 4,
  parameter int IRQ_CAUSE_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic [31:0]        ex_instr,
  input  logic               illegal_instruction,
  input  logic               ecall,
  input  logic               ebreak,
  input  logic               mret,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] mie_mask,
  input  logic [XLEN-1:0]    mtvec,
  input  logic               csr_we,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    mepc,
  output logic [XLEN-1:0]    mcause,
  output logic [XLEN-1:0]    mtval,
  output logic               mstatus_mie,
  output logic               mstatus_mpie,
  output logic               busy,
  output logic               flush,
  output logic               pc_redirect,
  output logic [XLEN-1:0]    pc_target
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  trap_state_e state_q, state_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d, pend_cause_q, pend_cause_d, pend_tval_q, pend_tval_d;
  logic            mie_q, mie_d, mpie_q, mpie_d;

  logic [NUM_IRQ-1:0]     irq_masked;
  logic                   irq_any, irq_take, exc_any, trap_accept, ret_accept;
  logic [IDX_W-1:0]       irq_idx;
  logic                   trap_intr;
  logic [IRQ_CAUSE_W-1:0] trap_code;
  logic [XLEN-1:0]        trap_tval, trap_base, trap_target;

  assign irq_masked = irq & mie_mask;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_irq_prio_enc (
    .req   (irq_masked),
    .valid (irq_any),
    .idx   (irq_idx)
  );

  assign irq_take    = mie_q & irq_any;
  assign exc_any     = illegal_instruction | ecall | ebreak;
  assign trap_accept = instr_valid & (exc_any | irq_take);
  assign ret_accept  = instr_valid & mret & ~(exc_any | irq_take);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mie_q        <= 1'b0;
      mpie_q       <= 1'b0;
      pend_pc_q    <= '0;
      pend_cause_q <= '0;
      pend_tval_q  <= '0;
    end else begin
      state_q      <= state_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      mtval_q      <= mtval_d;
      mie_q        <= mie_d;
      mpie_q       <= mpie_d;
      pend_pc_q    <= pend_pc_d;
      pend_cause_q <= pend_cause_d;
      pend_tval_q  <= pend_tval_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (trap_accept)     state_d = ST_SAVE;
        else if (ret_accept) state_d = ST_RET;
      end
      ST_SAVE:     state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      ST_RET:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Cause selection; the trap is latched at acceptance so EX may move on.
  always_comb begin
    trap_intr = 1'b0;
    trap_code = '0;
    trap_tval = '0;
    if (illegal_instruction) begin
      trap_code = IRQ_CAUSE_W'(CAUSE_ILLEGAL);
      trap_tval = XLEN'(ex_instr);
    end else if (ebreak) begin
      trap_code = IRQ_CAUSE_W'(CAUSE_BREAK);
      trap_tval = ex_pc;
    end else if (ecall) begin
      trap_code = IRQ_CAUSE_W'(CAUSE_ECALL_M);
    end else begin
      trap_intr = 1'b1;
      trap_code = IRQ_CAUSE_W'(IRQ_CAUSE_BASE) + IRQ_CAUSE_W'(irq_idx);
    end
  end

  always_comb begin
    pend_pc_d    = pend_pc_q;
    pend_cause_d = pend_cause_q;
    pend_tval_d  = pend_tval_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    mtval_d      = mtval_q;
    mie_d        = mie_q;
    mpie_d       = mpie_q;
    case (state_q)
      ST_IDLE: begin
        if (trap_accept) begin
          pend_pc_d                      = {ex_pc[XLEN-1:2], 2'b00};
          pend_cause_d                   = '0;
          pend_cause_d[XLEN-1]           = trap_intr;
          pend_cause_d[IRQ_CAUSE_W-1:0]  = trap_code;
          pend_tval_d                    = trap_tval;
        end
        if (csr_we) begin
          case (csr_addr)
            CSR_MEPC:    mepc_d   = {csr_wdata[XLEN-1:2], 2'b00};
            CSR_MCAUSE:  mcause_d = csr_wdata;
            CSR_MTVAL:   mtval_d  = csr_wdata;
            CSR_MSTATUS: begin
              mie_d  = csr_wdata[MSTATUS_MIE_BIT];
              mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
            end
            default: ;
          endcase
        end
      end
      ST_SAVE: begin
        mepc_d   = pend_pc_q;
        mcause_d = pend_cause_q;
        mtval_d  = pend_tval_q;
        mpie_d   = mie_q;
        mie_d    = 1'b0;
      end
      ST_RET: begin
        mie_d  = mpie_q;
        mpie_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign trap_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  always_comb begin
    trap_target = trap_base;
    if (mtvec[1:0] == 2'b01 && mcause_q[XLEN-1])
      trap_target = trap_base + (XLEN'(mcause_q[IRQ_CAUSE_W-1:0]) << 2);
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];
  assign trap_target       = trap_base;
`endif

  always_comb begin
    busy        = (state_q != ST_IDLE);
    flush       = (state_q == ST_SAVE) || (state_q == ST_RET);
    pc_redirect = (state_q == ST_REDIRECT) || (state_q == ST_RET);
    pc_target   = '0;
    if (state_q == ST_REDIRECT) pc_target = trap_target;
    else if (state_q == ST_RET) pc_target = mepc_q;
  end

  assign mepc         = mepc_q;
  assign mcause       = mcause_q;
  assign mtval        = mtval_q;
  assign mstatus_mie  = mie_q;
  assign mstatus_mpie = mpie_q;

endmodule

// File: tb/tb_trap_unit.sv
// Directed self-checking bench for trap_unit (default or TRAP_VECTORED_EN build).
module tb_trap_unit;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] IRQ17_TARGET = 32'h0000_0244;
`else
  localparam logic [31:0] IRQ17_TARGET = 32'h0000_0200;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] ex_pc, ex_instr;
  logic        illegal_instruction, ecall, ebreak, mret;
  logic [3:0]  irq, mie_mask;
  logic [31:0] mtvec;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] mepc, mcause, mtval, pc_target;
  logic        mstatus_mie, mstatus_mpie, busy, flush, pc_redirect;

  int n_compared   = 0;
  int n_mismatched = 0;

  trap_unit dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .illegal_instruction(illegal_instruction), .ecall(ecall), .ebreak(ebreak), .mret(mret),
    .irq(irq), .mie_mask(mie_mask), .mtvec(mtvec), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .mepc(mepc), .mcause(mcause), .mtval(mtval),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .busy(busy), .flush(flush),
    .pc_redirect(pc_redirect), .pc_target(pc_target)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_valid = 0; ex_pc = 0; ex_instr = 0;
    illegal_instruction = 0; ecall = 0; ebreak = 0; mret = 0;
    irq = 0; mie_mask = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we = 1; csr_addr = addr; csr_wdata = data;
    tick();
    csr_we = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
    n_compared++; if ({flush, pc_redirect} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_strobes: got %b expected 00", {flush, pc_redirect}); end
    n_compared++; if (pc_target !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_target: got %h expected 0", pc_target); end
    n_compared++; if ({mepc, mcause, mtval} !== 96'h0) begin n_mismatched++; $display("[TB] FAIL reset_csrs: got %h %h %h expected 0", mepc, mcause, mtval); end
    n_compared++; if ({mstatus_mie, mstatus_mpie} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_mstatus: got %b expected 00", {mstatus_mie, mstatus_mpie}); end
  endtask

  task automatic test_illegal();
    mtvec = 32'h200;
    instr_valid = 1; illegal_instruction = 1; ebreak = 1; ex_pc = 32'h100; ex_instr = 32'hFFFF_FFFF;
    tick();
    clear_inputs();
    n_compared++; if ({busy, flush, pc_redirect} !== 3'b110) begin n_mismatched++; $display("[TB] FAIL illegal_save_cycle: got %b expected 110", {busy, flush, pc_redirect}); end
    tick();
    n_compared++; if ({pc_redirect, flush} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL illegal_redirect_cycle: got %b expected 10", {pc_redirect, flush}); end
    n_compared++; if (pc_target !== 32'h200) begin n_mismatched++; $display("[TB] FAIL illegal_target: got %h expected 00000200", pc_target); end
    n_compared++; if (mepc !== 32'h100) begin n_mismatched++; $display("[TB] FAIL illegal_mepc: got %h expected 00000100", mepc); end
    n_compared++; if (mcause !== 32'h2) begin n_mismatched++; $display("[TB] FAIL illegal_mcause: got %h expected 00000002", mcause); end
    n_compared++; if (mtval !== 32'hFFFF_FFFF) begin n_mismatched++; $display("[TB] FAIL illegal_mtval: got %h expected ffffffff", mtval); end
    n_compared++; if (mstatus_mie !== 1'b0) begin n_mismatched++; $display("[TB] FAIL illegal_mie: got %0h expected 0", mstatus_mie); end
    tick();
    n_compared++; if ({busy, pc_redirect} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL illegal_back_idle: got %b expected 00", {busy, pc_redirect}); end
  endtask

  task automatic test_ebreak();
    instr_valid = 1; ebreak = 1; ecall = 1; ex_pc = 32'h124; ex_instr = 32'h0010_0073;
    tick(); clear_inputs(); tick();
    n_compared++; if (mcause !== 32'h3) begin n_mismatched++; $display("[TB] FAIL ebreak_mcause: got %h expected 00000003", mcause); end
    n_compared++; if (mtval !== 32'h124) begin n_mismatched++; $display("[TB] FAIL ebreak_mtval: got %h expected 00000124", mtval); end
    tick();
  endtask

  task automatic test_irq();
    csr_write(12'h300, 32'h8);
    n_compared++; if ({mstatus_mie, mstatus_mpie} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL irq_mstatus_write: got %b expected 10", {mstatus_mie, mstatus_mpie}); end
    mtvec = 32'h201;
    instr_valid = 1; irq = 4'b0110; mie_mask = 4'b1111; ex_pc = 32'h180;
    tick(); clear_inputs();
    n_compared++; if (flush !== 1'b1) begin n_mismatched++; $display("[TB] FAIL irq_flush: got %0h expected 1", flush); end
    tick();
    n_compared++; if (mcause !== 32'h8000_0011) begin n_mismatched++; $display("[TB] FAIL irq_mcause: got %h expected 80000011", mcause); end
    n_compared++; if (mtval !== 32'h0) begin n_mismatched++; $display("[TB] FAIL irq_mtval: got %h expected 0", mtval); end
    n_compared++; if (mepc !== 32'h180) begin n_mismatched++; $display("[TB] FAIL irq_mepc: got %h expected 00000180", mepc); end
    n_compared++; if (pc_target !== IRQ17_TARGET) begin n_mismatched++; $display("[TB] FAIL irq_target: got %h expected %h", pc_target, IRQ17_TARGET); end
    n_compared++; if ({mstatus_mie, mstatus_mpie} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL irq_mstatus: got %b expected 01", {mstatus_mie, mstatus_mpie}); end
    tick();
  endtask

  task automatic test_mret();
    instr_valid = 1; mret = 1;
    tick(); clear_inputs();
    n_compared++; if ({busy, flush, pc_redirect} !== 3'b111) begin n_mismatched++; $display("[TB] FAIL mret_strobes: got %b expected 111", {busy, flush, pc_redirect}); end
    n_compared++; if (pc_target !== 32'h180) begin n_mismatched++; $display("[TB] FAIL mret_target: got %h expected 00000180", pc_target); end
    tick();
    n_compared++; if ({busy, pc_redirect} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL mret_done: got %b expected 00", {busy, pc_redirect}); end
    n_compared++; if ({mstatus_mie, mstatus_mpie} !== 2'b11) begin n_mismatched++; $display("[TB] FAIL mret_mstatus: got %b expected 11", {mstatus_mie, mstatus_mpie}); end
  endtask

  task automatic test_csr_write();
    csr_write(12'h341, 32'h303);
    n_compared++; if (mepc !== 32'h300) begin n_mismatched++; $display("[TB] FAIL csr_mepc_align: got %h expected 00000300", mepc); end
    csr_write(12'h343, 32'hABCD_0001);
    n_compared++; if (mtval !== 32'hABCD_0001) begin n_mismatched++; $display("[TB] FAIL csr_mtval: got %h expected abcd0001", mtval); end
    instr_valid = 1; ecall = 1; ex_pc = 32'h400;
    tick(); clear_inputs();
    csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h555;
    tick(); csr_we = 0;
    n_compared++; if (mepc !== 32'h400) begin n_mismatched++; $display("[TB] FAIL csr_drop_in_save: got %h expected 00000400", mepc); end
    n_compared++; if (mcause !== 32'hB) begin n_mismatched++; $display("[TB] FAIL ecall_mcause: got %h expected 0000000b", mcause); end
    n_compared++; if (mtval !== 32'h0) begin n_mismatched++; $display("[TB] FAIL ecall_mtval: got %h expected 0", mtval); end
    tick();
  endtask

  task automatic test_priority();
    csr_write(12'h300, 32'h88);
    instr_valid = 1; ecall = 1; irq = 4'b0001; mie_mask = 4'b1111; ex_pc = 32'h500;
    tick(); clear_inputs(); tick();
    n_compared++; if (mcause !== 32'hB) begin n_mismatched++; $display("[TB] FAIL prio_ecall_over_irq: got %h expected 0000000b", mcause); end
    n_compared++; if (pc_target !== 32'h200) begin n_mismatched++; $display("[TB] FAIL prio_exc_to_base: got %h expected 00000200", pc_target); end
    tick();
    instr_valid = 1; irq = 4'b1000; mie_mask = 4'b1111; ex_pc = 32'h600;
    tick();
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL irq_disabled_busy: got %0h expected 0", busy); end
    csr_write(12'h300, 32'h8);
    irq = 4'b0010; mie_mask = 4'b1101;
    tick();
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL irq_masked_busy: got %0h expected 0", busy); end
    irq = 4'b1000; mie_mask = 4'b1111;
    tick(); clear_inputs(); tick();
    n_compared++; if (mcause !== 32'h8000_0013) begin n_mismatched++; $display("[TB] FAIL irq3_mcause: got %h expected 80000013", mcause); end
    tick();
  endtask

  task automatic test_reset_mid();
    instr_valid = 1; illegal_instruction = 1; ex_pc = 32'h700; ex_instr = 32'h1234_5678;
    tick(); clear_inputs(); tick();
    n_compared++; if (pc_redirect !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_in_redirect: got %0h expected 1", pc_redirect); end
    rst = 1;
    tick();
    rst = 0;
    n_compared++; if ({busy, pc_redirect, flush} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL midreset_idle: got %b expected 000", {busy, pc_redirect, flush}); end
    n_compared++; if ({mepc, mcause, mtval} !== 96'h0) begin n_mismatched++; $display("[TB] FAIL midreset_csrs: got %h %h %h expected 0", mepc, mcause, mtval); end
    n_compared++; if ({mstatus_mie, mstatus_mpie} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL midreset_mstatus: got %b expected 00", {mstatus_mie, mstatus_mpie}); end
  endtask

  initial begin
    clear_inputs();
    mtvec = 0;
    rst = 1;
    test_reset();
    test_illegal();
    test_ebreak();
    test_irq();
    test_mret();
    test_csr_write();
    test_priority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/trap_unit.md
Name: trap_unit

Overview:
Parametrised machine-mode trap sequencer for the RV32I core. It sits beside the decode controller, which supplies illegal_instruction, mret, ecall and ebreak flags for the instruction in EX. The block owns mepc, mcause, mtval and mstatus.MIE/MPIE, prioritises exceptions over NUM_IRQ interrupt lines, and runs a short FSM that saves state, flushes the pipeline and redirects the PC.

Parameters:
XLEN, 32, datapath / CSR width
NUM_IRQ, 4, interrupt lines; irq[i] maps to mcause code 16+i
IRQ_CAUSE_W, 5, width of mcause exception-code field

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
instr_valid  in  1  EX-stage instruction valid and not stalled
ex_pc  in  XLEN  PC of EX instruction
ex_instr  in  32  raw EX instruction (mtval on illegal)
illegal_instruction  in  1  from controller
ecall  in  1  ECALL decoded
ebreak  in  1  EBREAK decoded
mret  in  1  from controller
irq  in  NUM_IRQ  level-sensitive interrupt requests
mie_mask  in  NUM_IRQ  per-line enables (mie CSR bits)
mtvec  in  XLEN  trap vector CSR
csr_we  in  1  CSR-instruction write strobe
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  CSR write data
mepc  out  XLEN  current mepc
mcause  out  XLEN  current mcause
mtval  out  XLEN  current mtval
mstatus_mie  out  1  global interrupt enable
mstatus_mpie  out  1  previous enable
busy  out  1  FSM not IDLE; pipeline must stall
flush  out  1  flush IF/ID/EX
pc_redirect  out  1  one-cycle PC override strobe
pc_target  out  XLEN  redirect address

Behaviour:
- Reset (synchronous, active-high) clears all registers and outputs to 0; state=IDLE. Reset mid-sequence aborts the sequence and clears state.
- States: IDLE, SAVE, REDIRECT, RET.
- IDLE→SAVE when instr_valid and (illegal_instruction|ecall|ebreak|irq_take); irq_take = mstatus_mie & |(irq & mie_mask).
- Priority: illegal (cause 2) > ebreak (3) > ecall (11) > interrupt with lowest index i (cause 16+i, mcause[XLEN-1]=1).
- In SAVE (1 cycle): mepc←ex_pc (interrupt: ex_pc, instruction not executed). mcause←{intr, cause}. mtval←ex_instr for illegal, ex_pc for ebreak, 0 otherwise. mpie←mie; mie←0. flush=1.
- REDIRECT (1 cycle): pc_redirect=1, pc_target={mtvec[XLEN-1:2],2'b00}; →IDLE.
- IDLE→RET on instr_valid & mret (exceptions take priority if both asserted). RET (1 cycle): mie←mpie, mpie←1, flush=1, pc_redirect=1, pc_target=mepc; →IDLE.
- busy=1 in SAVE/REDIRECT/RET. Total trap latency is 2 cycles from acceptance to redirect; mret latency is 1 cycle.
- CSR writes (0x341 mepc, 0x342 mcause, 0x343 mtval, 0x300 mstatus bits 3/7) apply in IDLE only. A write colliding with SAVE/RET is dropped: the trap update wins. mepc[1:0] is always forced to 0.
- irq is sampled only in IDLE; a deasserted line before acceptance is not taken.

Optional Feature:
TRAP_VECTORED_EN. When defined and mtvec[1:0]==2'b01, interrupt pc_target = base + 4*cause_code (XLEN-bit add, wrap ignored); exceptions still go to base. When undefined, mtvec[1:0] is ignored and all traps go to base.

Decomposition:
- Package trap_pkg holds: the state enum; cause constants (CAUSE_ILLEGAL=2, CAUSE_BREAK=3, CAUSE_ECALL_M=11, IRQ_CAUSE_BASE=16); CSR address constants.
- Sub-module irq_prio_enc: parametrised NUM_IRQ lowest-index priority encoder returning valid plus index.

Test Plan:
- Reset, then illegal_instruction with ex_pc=0x100, ex_instr=0xFFFFFFFF, mtvec=0x200 → mepc=0x100, mcause=2, mtval=0xFFFFFFFF, flush cycle+1, pc_redirect/pc_target=0x200 cycle+2, mie=0.
- mstatus_mie=1, irq=4'b0110, mie_mask=4'b1111 → mcause=0x80000011, mtval=0. With TRAP_VECTORED_EN and mtvec=0x201 → pc_target=0x244.
- mret after a trap with mpie=1 → single-cycle redirect to mepc, mie=1, mpie=1.
- csr_we to 0x341 with data 0x303 in IDLE → mepc=0x300. The same write issued during SAVE is dropped.
- ecall and irq together with mie=1 → mcause=11. irq with mstatus_mie=0 → no trap, busy stays 0.
- rst asserted in REDIRECT → next cycle state IDLE, pc_redirect=0, all CSRs 0.
